// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg: shared types and helpers for the load/store unit.
//   lsu_state_e : FSM state encoding (IDLE, REQ, WAIT, RESP)
//   SZ_B..SZ_D  : access size encodings used on req_size
//   misaligned(): flags an access whose address is not a multiple of its
//                 size, or a dword access on a 32-bit datapath
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    function automatic logic misaligned(input logic [2:0] addr_lo,
                                        input logic [1:0] size,
                                        input logic       xlen32);
        logic [2:0] mask;
        case (size)
            SZ_B:    mask = 3'b000;
            SZ_H:    mask = 3'b001;
            SZ_W:    mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return ((addr_lo & mask) != 3'b000) || ((size == SZ_D) && xlen32);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_if: core-side request/response and data-bus signals of the LSU.
//   master : LSU view (accepts core requests, issues bus requests)
//   slave  : environment view (memory stage + writeback + bus memory)
// Core side : req_valid/ready/store/addr/wdata/size/unsigned/rd,
//             resp_valid/data/rd/err, stall
// Bus side  : bus_req_valid/ready, bus_we/addr/wdata/wstrb,
//             bus_rsp_valid/data/err
// ---------------------------------------------------------------------------
interface lsu_if #(parameter int XLEN = 64);

    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [4:0]        req_rd;

    logic              resp_valid;
    logic [XLEN-1:0]   resp_data;
    logic [4:0]        resp_rd;
    logic              resp_err;
    logic              stall;

    logic              bus_req_valid;
    logic              bus_req_ready;
    logic              bus_we;
    logic [XLEN-1:0]   bus_addr;
    logic [XLEN-1:0]   bus_wdata;
    logic [XLEN/8-1:0] bus_wstrb;
    logic              bus_rsp_valid;
    logic [XLEN-1:0]   bus_rsp_data;
    logic              bus_rsp_err;

    modport master (
        input  req_valid, req_store, req_addr, req_wdata, req_size,
               req_unsigned, req_rd,
        output req_ready, resp_valid, resp_data, resp_rd, resp_err, stall,
        output bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_data, bus_rsp_err
    );

    modport slave (
        output req_valid, req_store, req_addr, req_wdata, req_size,
               req_unsigned, req_rd,
        input  req_ready, resp_valid, resp_data, resp_rd, resp_err, stall,
        input  bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_req_ready, bus_rsp_valid, bus_rsp_data, bus_rsp_err
    );

endinterface

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align: combinational lane alignment for the LSU.
//   size_i/off_i/unsigned_i : access size, byte offset within the bus word,
//                             zero-extend select
//   wdata_i -> wdata_o      : store data shifted into its byte lanes
//   wstrb_o                 : byte-lane enables for a store
//   rdata_i -> rdata_o      : load data extracted from its lanes and
//                             sign/zero-extended to XLEN
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int XLEN = 64,
    localparam int NB   = XLEN / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  logic [1:0]      size_i,
    input  logic [OFFW-1:0] off_i,
    input  logic            unsigned_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] wdata_o,
    output logic [NB-1:0]   wstrb_o,
    output logic [XLEN-1:0] rdata_o
);

    logic [NB-1:0]   mask;
    logic [XLEN-1:0] rd_sh;
    logic            fill;

    assign wdata_o = wdata_i << {off_i, 3'b000};
    assign rd_sh   = rdata_i >> {off_i, 3'b000};

    always_comb begin
        mask = '0;
        for (int i = 0; i < NB; i++) begin
            mask[i] = (i < (1 << size_i));
        end
        wstrb_o = mask << off_i;
    end

    // Sign bit sits at the top of the accessed width; dword uses XLEN-1,
    // which on a 32-bit datapath only matters for an already-failed access.
    always_comb begin
        case (size_i)
            SZ_B:    fill = rd_sh[7];
            SZ_H:    fill = rd_sh[15];
            SZ_W:    fill = rd_sh[31];
            default: fill = rd_sh[XLEN-1];
        endcase
        fill = fill & ~unsigned_i;
        rdata_o = '0;
        for (int i = 0; i < XLEN; i++) begin
            rdata_o[i] = (i < (8 << size_i)) ? rd_sh[i] : fill;
        end
    end

endmodule

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu: registered load/store engine between the memory stage and a
// handshake data bus (IDLE -> REQ -> WAIT -> RESP).
//   clk, rstn : clock, synchronous active-low reset
//   io        : lsu_if.master carrying core request/response, stall and
//               the bus request/response channels
// Parameters : XLEN (32 or 64), TIMEOUT (watchdog limit in cycles)
// Optional   : define LSU_TIMEOUT_EN to add a watchdog that ends an access
//              with an error after TIMEOUT cycles in REQ/WAIT.
// ---------------------------------------------------------------------------
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic   clk,
    input  logic   rstn,
    lsu_if.master  io
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    lsu_state_e      state_q, state_d;
    logic            store_q, unsigned_q, err_q;
    logic [1:0]      size_q;
    logic [XLEN-1:0] addr_q, wdata_q, resp_data_q;
    logic [4:0]      rd_q;

    logic [XLEN-1:0] wdata_sh, rdata_ext;
    logic [NB-1:0]   wstrb;
    logic            accept, mis, tmo_hit;

    assign accept = (state_q == ST_IDLE) && io.req_valid;
    assign mis    = misaligned(io.req_addr[2:0], io.req_size, XLEN == 32);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 256) ? 8 : $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Held at zero in IDLE, so it is clear on entry to REQ.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) cnt_d = '0;
        else if (state_q == ST_REQ || state_q == ST_WAIT) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Fires in the cycle whose increment would reach TIMEOUT.
    assign tmo_hit = (state_q == ST_REQ || state_q == ST_WAIT) &&
                     (cnt_q >= CNT_W'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    lsu_align #(.XLEN(XLEN)) u_align (
        .size_i     (size_q),
        .off_i      (addr_q[OFFW-1:0]),
        .unsigned_i (unsigned_q),
        .wdata_i    (wdata_q),
        .rdata_i    (io.bus_rsp_data),
        .wdata_o    (wdata_sh),
        .wstrb_o    (wstrb),
        .rdata_o    (rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (io.req_valid) state_d = mis ? ST_RESP : ST_REQ;
            ST_REQ: begin
                if (io.bus_req_ready) state_d = ST_WAIT;
                else if (tmo_hit)     state_d = ST_RESP;
            end
            ST_WAIT: if (io.bus_rsp_valid || tmo_hit) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Response-visible fields are reset; the load result is extended on the
    // way in so RESP only has to present a register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            store_q     <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            rd_q        <= '0;
            resp_data_q <= '0;
        end else if (accept) begin
            store_q     <= io.req_store;
            err_q       <= mis;
            addr_q      <= io.req_addr;
            rd_q        <= io.req_rd;
            resp_data_q <= '0;
        end else if (state_q == ST_WAIT && io.bus_rsp_valid) begin
            err_q       <= io.bus_rsp_err;
            resp_data_q <= (store_q || io.bus_rsp_err) ? '0 : rdata_ext;
        end else if (tmo_hit && state_d == ST_RESP) begin
            err_q       <= 1'b1;
            resp_data_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wdata_q    <= io.req_wdata;
            size_q     <= io.req_size;
            unsigned_q <= io.req_unsigned;
        end
    end

    always_comb begin
        io.req_ready     = (state_q == ST_IDLE);
        io.stall         = (state_q != ST_IDLE);
        io.resp_valid    = (state_q == ST_RESP);
        io.resp_err      = (state_q == ST_RESP) && err_q;
        io.resp_data     = resp_data_q;
        io.resp_rd       = rd_q;
        io.bus_req_valid = (state_q == ST_REQ);
        io.bus_we        = (state_q == ST_REQ) && store_q;
        io.bus_addr      = {addr_q[XLEN-1:OFFW], OFFW'(0)};
        io.bus_wdata     = wdata_sh;
        io.bus_wstrb     = ((state_q == ST_REQ) && store_q) ? wstrb : '0;
    end

endmodule

// File: doc/lsu.md
# lsu

Parametrised load/store unit for the pipelined core, sitting between the memory stage and a handshake data bus. It replaces the zero-latency, combinational memory access of the current pipeline with a registered request/response engine. The engine tolerates variable bus latency, aligns and extends data for XLEN 32 or 64, and raises `stall` so that upstream stages hold while an access is in flight.

## Interface
- `XLEN`, 64: datapath width, 32 or 64; bus data width equals XLEN.
- `TIMEOUT`, 255: watchdog limit in cycles; used only when the timeout feature is compiled in.
- `clk` in 1: single clock.
- `rstn` in 1: reset, synchronous, active-low.
- `req_valid` in 1: memory stage presents an access.
- `req_ready` out 1: LSU can accept an access; high only in IDLE.
- `req_store` in 1: 1 = store, 0 = load.
- `req_addr` in XLEN: byte address.
- `req_wdata` in XLEN: store data, LSB-aligned.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = dword.
- `req_unsigned` in 1: zero-extend the load result.
- `req_rd` in 5: destination register index, returned with the response.
- `resp_valid` out 1: one-cycle pulse; the access is complete.
- `resp_data` out XLEN: extended load data; 0 for stores and errors.
- `resp_rd` out 5: captured `req_rd`.
- `resp_err` out 1: the access was misaligned, used an illegal size, got a bus error, or timed out.
- `stall` out 1: high whenever state is not IDLE.
- `bus_req_valid` out 1: bus request.
- `bus_req_ready` in 1: bus accepts the request.
- `bus_we` out 1: write request.
- `bus_addr` out XLEN: `req_addr` with the low log2(XLEN/8) bits cleared.
- `bus_wdata` out XLEN: store data shifted into its byte lanes.
- `bus_wstrb` out XLEN/8: byte-lane enables for the write.
- `bus_rsp_valid` in 1: read data is valid, or the write is acknowledged.
- `bus_rsp_data` in XLEN: read data, full lane width.
- `bus_rsp_err` in 1: bus error.

## Operation
- The FSM has four states: IDLE, REQ, WAIT, RESP.
- IDLE
  - On `req_valid`, latch all request fields.
  - If the access is misaligned (`addr` not a multiple of 1<<size) or `size==3` with `XLEN==32`, go to RESP with the error flag set. No bus traffic is issued.
  - Otherwise go to REQ.
- REQ
  - Drive `bus_req_valid`, `bus_we`, `bus_addr`, `bus_wdata` and `bus_wstrb` from registers; they are held stable until `bus_req_ready`.
  - On `bus_req_ready`, go to WAIT.
- WAIT
  - On `bus_rsp_valid`, register the data and `bus_rsp_err`, then go to RESP.
- RESP
  - Drive `resp_valid=1` for one cycle, then go to IDLE.
- Lane offset `off = addr[log2(XLEN/8)-1:0]`.
  - Write strobe: `((1<<(1<<size))-1) << off`.
  - Write data: `req_wdata << (8*off)`.
- Load result: `bus_rsp_data >> (8*off)`, truncated to 1<<size bytes, then sign- or zero-extended to XLEN according to `req_unsigned`. Store responses return `resp_data=0`.
- `bus_rsp_valid` is ignored in IDLE, REQ and RESP.
- There is no response backpressure: writeback always accepts `resp_valid`.

## Timing
- Reset values, with `rstn` low at a clock edge:
  - State goes to IDLE.
  - `resp_valid`, `resp_err`, `bus_req_valid`, `bus_we` and `bus_wstrb` are 0.
  - `resp_data`, `resp_rd` and `bus_addr` are 0.
- Reset mid-operation abandons the access. A late `bus_rsp_valid` arriving after reset is ignored.
- An access accepted in cycle 0 has `bus_req_valid` high in cycle 1.
- With `bus_req_ready` high in cycle 1 and `bus_rsp_valid` high in cycle 2, `resp_valid` is high in cycle 3. This is the minimum latency: 3 cycles.
- A misaligned access accepted in cycle 0 gets `resp_valid` with `resp_err` in cycle 1.
- `req_ready` and `stall` are combinational from the state. `req_ready = (state==IDLE)` and `stall = !req_ready`.
- A new request may be accepted in the cycle after RESP. Throughput is at most one access per 4 cycles.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - An 8+-bit counter clears on entering REQ and increments in REQ and WAIT.
  - When it reaches `TIMEOUT` without `bus_rsp_valid`, the FSM goes to RESP with `resp_err=1` and `resp_data=0`.
  - `bus_req_valid` drops.
- `LSU_TIMEOUT_EN` undefined:
  - There is no counter.
  - The FSM waits indefinitely.
  - `TIMEOUT` is unused.

## Structure
- `lsu_pkg` holds:
  - the state enum;
  - the size encodings (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`);
  - a misalignment-check function.
- Sub-module `lsu_align` is purely combinational. It takes XLEN, size, offset and unsigned as inputs and produces the write-lane shift, the write strobe and the load extract/extend. The FSM file instantiates it once.

## Test plan
- XLEN=64, `lw` from addr 0x8000_0004, `bus_rsp_data`=0x8000_0001_0000_0000, zero-wait bus:
  - `bus_addr`=0x8000_0000;
  - `resp_data`=0xFFFF_FFFF_8000_0001 in cycle 3;
  - `resp_rd` echoed.
- `sb` of 0xAB to addr 0x1003:
  - `bus_wstrb`=0x08;
  - `bus_wdata[31:24]`=0xAB;
  - `bus_we`=1;
  - the write ack gives `resp_valid`, `resp_err=0` and `resp_data=0`.
- `lh` from addr 0x1001:
  - `resp_err=1` in cycle 1;
  - `bus_req_valid` never rises.
- `bus_req_ready` held low 5 cycles, then response after 3 more cycles:
  - request fields are stable throughout;
  - `stall` is high the whole time;
  - `resp_valid` is exactly one cycle.
- `rstn` low during WAIT, then a stray `bus_rsp_valid`:
  - back in IDLE;
  - no `resp_valid`;
  - `req_ready`=1.
- With `LSU_TIMEOUT_EN` and TIMEOUT=16, no bus response:
  - `resp_err=1` 16 cycles after entering REQ.
- Repeat the first case with XLEN=32, `ld`:
  - `resp_err=1`.
